// File: rtl/pwm_mode_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pwm_mode_sequencer_pkg
// Shared definitions for the PWM mode sequencer and its helper blocks:
//   state_e        FSM state encoding (also exported on state_dbg)
//   FCODE_*        fault_code values
//   PWM_MODE_*     comparator mode select values
//   max_int        helper used to size the shared counter
// -----------------------------------------------------------------------------
package pwm_mode_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_BLANK = 3'd4,
    ST_FAULT = 3'd5
  } state_e;

  localparam logic [1:0] FCODE_NONE    = 2'b00;
  localparam logic [1:0] FCODE_EXT     = 2'b01;
  localparam logic [1:0] FCODE_TIMEOUT = 2'b10;

  localparam logic PWM_MODE_UNI = 1'b0;
  localparam logic PWM_MODE_BI  = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/carrier_valley_detect.sv
// -----------------------------------------------------------------------------
// carrier_valley_detect
// Tracks the direction of a signed triangular carrier and flags the sample at
// which it turns from falling to rising (the valley).
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   sample_i  in   signed carrier sample (DW bits)
//   valley_o  out  high for the one sample that first rises after a descent
// -----------------------------------------------------------------------------
module carrier_valley_detect #(
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] sample_i,
  output logic                 valley_o
);

  logic signed [DW-1:0] prev_q;
  logic                 down_q;
  logic                 down_d;

  // Equal consecutive samples hold the previous direction, so a flat bottom
  // still produces a valley when the carrier starts rising again.
  always_comb begin
    down_d = down_q;
    if (sample_i < prev_q) begin
      down_d = 1'b1;
    end else if (sample_i > prev_q) begin
      down_d = 1'b0;
    end
  end

  assign valley_o = down_q & (sample_i > prev_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      down_q <= 1'b0;
    end else begin
      prev_q <= sample_i;
      down_q <= down_d;
    end
  end

endmodule

// File: rtl/pwm_mode_sequencer.sv
// -----------------------------------------------------------------------------
// pwm_mode_sequencer
// Run-time controller for the PWM comparator stage. Owns pwm_mode and the
// out_enable gate; applies mode changes only at a carrier valley with a
// dead-time blank in between; handles enable, external faults and carrier loss.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   tri_wave      signed carrier sample (DW bits)
//   enable        level, 1 = run PWM
//   req_valid/req_mode/req_ready   mode-change request handshake
//   fault_in      external fault level
//   fault_clr     pulse, clears a latched fault when fault_in is low
//   pwm_mode      mode select to comparator (0 unipolar, 1 bipolar)
//   out_enable    comparator output gate
//   switch_done   pulse when an accepted request is fully applied
//   req_abort     pulse when an accepted request is dropped
//   fault_flag    latched fault present
//   fault_code    00 none, 01 external, 10 carrier timeout
//   state_dbg     current FSM state encoding
// -----------------------------------------------------------------------------
module pwm_mode_sequencer
  import pwm_mode_sequencer_pkg::*;
#(
  parameter int DW           = 16,
  parameter int DEADTIME     = 64,
  parameter int SYNC_TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] tri_wave,
  input  logic          enable,
  input  logic          req_valid,
  input  logic          req_mode,
  output logic          req_ready,
  input  logic          fault_in,
  input  logic          fault_clr,
  output logic          pwm_mode,
  output logic          out_enable,
  output logic          switch_done,
  output logic          req_abort,
  output logic          fault_flag,
  output logic [1:0]    fault_code,
  output logic [2:0]    state_dbg
);

  // One counter serves both the dead-time blank and the valley timeout;
  // it only ever needs to reach (limit - 1).
  localparam int CNT_MAX = max_int(DEADTIME, SYNC_TIMEOUT);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DT_LAST = CW'(DEADTIME - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(SYNC_TIMEOUT - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          pwm_mode_q;
  logic          target_q;
  logic          pend_q;
  logic          out_enable_q;
  logic          req_ready_q;
  logic          switch_done_q;
  logic          req_abort_q;
  logic          fault_flag_q;
  logic [1:0]    fault_code_q;
  logic          valley;

  carrier_valley_detect #(
    .DW(DW)
  ) u_valley (
    .clk      (clk),
    .reset    (reset),
    .sample_i (tri_wave),
    .valley_o (valley)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      pwm_mode_q    <= PWM_MODE_UNI;
      target_q      <= PWM_MODE_UNI;
      pend_q        <= 1'b0;
      out_enable_q  <= 1'b0;
      req_ready_q   <= 1'b0;
      switch_done_q <= 1'b0;
      req_abort_q   <= 1'b0;
      fault_flag_q  <= 1'b0;
      fault_code_q  <= FCODE_NONE;
    end else begin
      switch_done_q <= 1'b0;
      req_abort_q   <= 1'b0;

      if (state_q != ST_FAULT && fault_in) begin
        // External fault overrides everything except reset.
        state_q      <= ST_FAULT;
        cnt_q        <= '0;
        out_enable_q <= 1'b0;
        req_ready_q  <= 1'b0;
        fault_flag_q <= 1'b1;
        fault_code_q <= FCODE_EXT;
        req_abort_q  <= pend_q;
        pend_q       <= 1'b0;
      end else if (state_q != ST_FAULT && !enable) begin
        // Disable wins over any request presented in the same cycle.
        state_q      <= ST_IDLE;
        cnt_q        <= '0;
        out_enable_q <= 1'b0;
        req_ready_q  <= 1'b0;
        req_abort_q  <= pend_q;
        pend_q       <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            // enable is known high here.
            state_q <= ST_SYNC;
            cnt_q   <= '0;
          end

          ST_SYNC: begin
            // A valley on the terminal-count cycle still counts as found.
            if (valley) begin
              state_q       <= ST_RUN;
              cnt_q         <= '0;
              out_enable_q  <= 1'b1;
              req_ready_q   <= 1'b1;
              switch_done_q <= pend_q;
              pend_q        <= 1'b0;
            end else if (cnt_q == TO_LAST) begin
              state_q      <= ST_FAULT;
              cnt_q        <= '0;
              out_enable_q <= 1'b0;
              req_ready_q  <= 1'b0;
              fault_flag_q <= 1'b1;
              fault_code_q <= FCODE_TIMEOUT;
              req_abort_q  <= pend_q;
              pend_q       <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end

          ST_RUN: begin
            if (req_valid && req_ready_q) begin
              if (req_mode == pwm_mode_q) begin
                switch_done_q <= 1'b1;
              end else begin
                target_q    <= req_mode;
                pend_q      <= 1'b1;
                req_ready_q <= 1'b0;
                state_q     <= ST_DRAIN;
                cnt_q       <= '0;
              end
            end
          end

          ST_DRAIN: begin
            // Old mode keeps running until the carrier reaches a valley.
            if (valley) begin
              state_q      <= ST_BLANK;
              cnt_q        <= '0;
              out_enable_q <= 1'b0;
            end else if (cnt_q == TO_LAST) begin
              state_q      <= ST_FAULT;
              cnt_q        <= '0;
              out_enable_q <= 1'b0;
              req_ready_q  <= 1'b0;
              fault_flag_q <= 1'b1;
              fault_code_q <= FCODE_TIMEOUT;
              req_abort_q  <= pend_q;
              pend_q       <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end

          ST_BLANK: begin
            if (cnt_q == DT_LAST) begin
              pwm_mode_q <= target_q;
              state_q    <= ST_SYNC;
              cnt_q      <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end

          ST_FAULT: begin
            // A clear is honoured only once the fault source has gone away.
            if (fault_clr && !fault_in) begin
              state_q      <= ST_IDLE;
              cnt_q        <= '0;
              fault_flag_q <= 1'b0;
              fault_code_q <= FCODE_NONE;
            end
          end

          default: begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            out_enable_q <= 1'b0;
            req_ready_q  <= 1'b0;
            pend_q       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign req_ready   = req_ready_q;
  assign pwm_mode    = pwm_mode_q;
  assign out_enable  = out_enable_q;
  assign switch_done = switch_done_q;
  assign req_abort   = req_abort_q;
  assign fault_flag  = fault_flag_q;
  assign fault_code  = fault_code_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_pwm_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pwm_mode_sequencer
// Directed bench: a vector table for the enable/sync/run/request path, then
// hand-written sequences for dead-time blanking, faults, timeout, disable and
// asynchronous reset. Inputs change on the falling edge; outputs are checked
// on the following falling edge.
// -----------------------------------------------------------------------------
module tb_pwm_mode_sequencer;

  localparam int DW = 16;
  localparam int DT = 64;
  localparam int TO = 100;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SYNC  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_BLANK = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] tri_wave;
  logic          enable, req_valid, req_mode, fault_in, fault_clr;
  logic          req_ready, pwm_mode, out_enable, switch_done, req_abort, fault_flag;
  logic [1:0]    fault_code;
  logic [2:0]    state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  pwm_mode_sequencer #(
    .DW(DW), .DEADTIME(DT), .SYNC_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .tri_wave(tri_wave), .enable(enable),
    .req_valid(req_valid), .req_mode(req_mode), .req_ready(req_ready),
    .fault_in(fault_in), .fault_clr(fault_clr), .pwm_mode(pwm_mode),
    .out_enable(out_enable), .switch_done(switch_done), .req_abort(req_abort),
    .fault_flag(fault_flag), .fault_code(fault_code), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [DW-1:0] carrier;
    logic                 en, rv, rm;
    logic                 oe, rdy, sd;
    logic [2:0]           st;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input int c, input bit en, input bit rv, input bit rm,
                              input bit oe, input bit rdy, input bit sd, input logic [2:0] st);
    vec_t v;
    v.carrier = DW'(c);
    v.en = en; v.rv = rv; v.rm = rm;
    v.oe = oe; v.rdy = rdy; v.sd = sd; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_carrier(input int c);
    tri_wave = DW'(c);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int blank_cycles;
  int sync_cycles;
  bit oe_high_in_blank;

  initial begin
    reset = 1'b1; tri_wave = '0; enable = 1'b0; req_valid = 1'b0;
    req_mode = 1'b0; fault_in = 1'b0; fault_clr = 1'b0;

    //           carrier en rv rm  oe rdy sd st
    vecs[0]  = mk(   0, 0, 0, 0,  0, 0, 0, S_IDLE);
    vecs[1]  = mk(   0, 1, 0, 0,  0, 0, 0, S_SYNC);
    vecs[2]  = mk(-100, 1, 0, 0,  0, 0, 0, S_SYNC);   // signed descent, not a valley
    vecs[3]  = mk(-200, 1, 0, 0,  0, 0, 0, S_SYNC);
    vecs[4]  = mk(-200, 1, 0, 0,  0, 0, 0, S_SYNC);   // flat: direction held
    vecs[5]  = mk(-100, 1, 0, 0,  1, 1, 0, S_RUN);    // valley
    vecs[6]  = mk(   0, 1, 0, 0,  1, 1, 0, S_RUN);
    vecs[7]  = mk( 100, 1, 1, 0,  1, 1, 1, S_RUN);    // same-mode request
    vecs[8]  = mk( 200, 1, 0, 0,  1, 1, 0, S_RUN);
    vecs[9]  = mk( 100, 1, 1, 1,  1, 0, 0, S_DRAIN);  // switch to bipolar
    vecs[10] = mk(   0, 1, 0, 0,  1, 0, 0, S_DRAIN);
    vecs[11] = mk(  50, 1, 0, 0,  0, 0, 0, S_BLANK);  // valley -> blank

    repeat (2) @(negedge clk);
    chk("reset_state",  {29'd0, state_dbg}, S_IDLE);
    chk("reset_outputs", {26'd0, req_ready, pwm_mode, out_enable, switch_done,
                          req_abort, fault_flag}, 32'd0);
    chk("reset_code", {30'd0, fault_code}, 32'd0);
    reset = 1'b0;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 12; i++) begin
      tri_wave  = vecs[i].carrier;
      enable    = vecs[i].en;
      req_valid = vecs[i].rv;
      req_mode  = vecs[i].rm;
      tick();
      $display("vec %0d: carrier=%0d en=%0b rv=%0b rm=%0b -> oe=%0b rdy=%0b sd=%0b st=%0d mode=%0b",
               i, vecs[i].carrier, vecs[i].en, vecs[i].rv, vecs[i].rm,
               out_enable, req_ready, switch_done, state_dbg, pwm_mode);
      chk($sformatf("vec%0d_oe", i),  {31'd0, out_enable},  {31'd0, vecs[i].oe});
      chk($sformatf("vec%0d_rdy", i), {31'd0, req_ready},   {31'd0, vecs[i].rdy});
      chk($sformatf("vec%0d_sd", i),  {31'd0, switch_done}, {31'd0, vecs[i].sd});
      chk($sformatf("vec%0d_st", i),  {29'd0, state_dbg},   {29'd0, vecs[i].st});
      chk($sformatf("vec%0d_mode", i), {31'd0, pwm_mode}, 32'd0);
    end
    req_valid = 1'b0;

    // ---------------- dead-time blank length ----------------
    blank_cycles = 0;
    oe_high_in_blank = 1'b0;
    while (state_dbg == S_BLANK && blank_cycles < 200) begin
      if (out_enable !== 1'b0 || pwm_mode !== 1'b0) oe_high_in_blank = 1'b1;
      blank_cycles++;
      tick();
    end
    $display("blank: %0d cycles, mode=%0b st=%0d", blank_cycles, pwm_mode, state_dbg);
    chk("blank_len", blank_cycles, DT);
    chk("blank_outputs_held", {31'd0, oe_high_in_blank}, 32'd0);
    chk("blank_exit_state", {29'd0, state_dbg}, S_SYNC);
    chk("blank_new_mode", {31'd0, pwm_mode}, 32'd1);
    chk("blank_exit_oe", {31'd0, out_enable}, 32'd0);

    set_carrier(40); tick();
    chk("resync_wait_oe", {31'd0, out_enable}, 32'd0);
    set_carrier(60); tick();
    $display("resync: oe=%0b sd=%0b st=%0d", out_enable, switch_done, state_dbg);
    chk("resync_state", {29'd0, state_dbg}, S_RUN);
    chk("resync_oe", {31'd0, out_enable}, 32'd1);
    chk("switch_done_pulse", {31'd0, switch_done}, 32'd1);
    tick();
    chk("switch_done_single", {31'd0, switch_done}, 32'd0);

    // ---------------- same-mode request while bipolar ----------------
    req_valid = 1'b1; req_mode = 1'b1; tick(); req_valid = 1'b0;
    $display("same-mode req: sd=%0b oe=%0b st=%0d", switch_done, out_enable, state_dbg);
    chk("same_sd", {31'd0, switch_done}, 32'd1);
    chk("same_oe", {31'd0, out_enable}, 32'd1);
    chk("same_state", {29'd0, state_dbg}, S_RUN);
    tick();
    chk("same_sd_clear", {31'd0, switch_done}, 32'd0);

    // ---------------- fault during BLANK ----------------
    req_valid = 1'b1; req_mode = 1'b0; tick(); req_valid = 1'b0;
    chk("f_drain", {29'd0, state_dbg}, S_DRAIN);
    set_carrier(30); tick();
    set_carrier(45); tick();
    chk("f_blank", {29'd0, state_dbg}, S_BLANK);
    repeat (3) tick();
    fault_in = 1'b1; set_carrier(0); tick(); fault_in = 1'b0;
    $display("fault: flag=%0b code=%0d abort=%0b oe=%0b st=%0d mode=%0b",
             fault_flag, fault_code, req_abort, out_enable, state_dbg, pwm_mode);
    chk("f_flag", {31'd0, fault_flag}, 32'd1);
    chk("f_code", {30'd0, fault_code}, 32'd1);
    chk("f_abort", {31'd0, req_abort}, 32'd1);
    chk("f_oe", {31'd0, out_enable}, 32'd0);
    chk("f_state", {29'd0, state_dbg}, S_FAULT);
    chk("f_mode_kept", {31'd0, pwm_mode}, 32'd1);
    tick();
    chk("f_abort_single", {31'd0, req_abort}, 32'd0);
    fault_in = 1'b1; fault_clr = 1'b1; tick(); fault_clr = 1'b0; fault_in = 1'b0;
    chk("f_clr_ignored", {29'd0, state_dbg}, S_FAULT);
    chk("f_clr_ignored_flag", {31'd0, fault_flag}, 32'd1);
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    $display("fault clear: st=%0d flag=%0b code=%0d", state_dbg, fault_flag, fault_code);
    chk("f_clr_state", {29'd0, state_dbg}, S_IDLE);
    chk("f_clr_flag", {31'd0, fault_flag}, 32'd0);
    chk("f_clr_code", {30'd0, fault_code}, 32'd0);

    // ---------------- carrier loss timeout ----------------
    tick();
    sync_cycles = 0;
    while (state_dbg == S_SYNC && sync_cycles < 300) begin
      sync_cycles++;
      tick();
    end
    $display("timeout: sync %0d cycles, st=%0d code=%0d", sync_cycles, state_dbg, fault_code);
    chk("to_len", sync_cycles, TO);
    chk("to_state", {29'd0, state_dbg}, S_FAULT);
    chk("to_code", {30'd0, fault_code}, 32'd2);
    chk("to_flag", {31'd0, fault_flag}, 32'd1);
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    chk("to_clr_state", {29'd0, state_dbg}, S_IDLE);

    // ---------------- disable during DRAIN ----------------
    tick();
    set_carrier(-10); tick();
    set_carrier(10);  tick();
    chk("d_run", {29'd0, state_dbg}, S_RUN);
    req_valid = 1'b1; req_mode = 1'b0; tick(); req_valid = 1'b0;
    chk("d_drain", {29'd0, state_dbg}, S_DRAIN);
    enable = 1'b0; tick();
    $display("disable in drain: st=%0d abort=%0b mode=%0b oe=%0b",
             state_dbg, req_abort, pwm_mode, out_enable);
    chk("d_state", {29'd0, state_dbg}, S_IDLE);
    chk("d_abort", {31'd0, req_abort}, 32'd1);
    chk("d_mode_kept", {31'd0, pwm_mode}, 32'd1);
    chk("d_oe", {31'd0, out_enable}, 32'd0);
    tick();
    chk("d_abort_single", {31'd0, req_abort}, 32'd0);

    // enable falling together with a request: not accepted
    enable = 1'b1; tick();
    set_carrier(-10); tick();
    set_carrier(10);  tick();
    chk("sim_run", {29'd0, state_dbg}, S_RUN);
    enable = 1'b0; req_valid = 1'b1; req_mode = 1'b0; tick(); req_valid = 1'b0;
    $display("disable+request: st=%0d sd=%0b abort=%0b mode=%0b",
             state_dbg, switch_done, req_abort, pwm_mode);
    chk("sim_state", {29'd0, state_dbg}, S_IDLE);
    chk("sim_no_abort", {31'd0, req_abort}, 32'd0);
    chk("sim_no_sd", {31'd0, switch_done}, 32'd0);
    chk("sim_mode", {31'd0, pwm_mode}, 32'd1);

    // ---------------- asynchronous reset mid-BLANK ----------------
    enable = 1'b1; tick();
    set_carrier(-10); tick();
    set_carrier(10);  tick();
    req_valid = 1'b1; req_mode = 1'b0; tick(); req_valid = 1'b0;
    set_carrier(-10); tick();
    set_carrier(10);  tick();
    chk("r_blank", {29'd0, state_dbg}, S_BLANK);
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    $display("async reset: st=%0d mode=%0b oe=%0b rdy=%0b flag=%0b",
             state_dbg, pwm_mode, out_enable, req_ready, fault_flag);
    chk("r_state", {29'd0, state_dbg}, S_IDLE);
    chk("r_mode", {31'd0, pwm_mode}, 32'd0);
    chk("r_outputs", {27'd0, req_ready, out_enable, switch_done, req_abort, fault_flag}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("r_after_state", {29'd0, state_dbg}, S_SYNC);
    chk("r_after_pulses", {30'd0, switch_done, req_abort}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
